// File: rtl/simon_host_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_host_if
// Desc     : Host-side driver for the SIMON 128/256 core. Packs upstream words
//            into key/block groups, runs the core handshake, drains results.
// Revision : 1.0 - initial release
// ============================================================================
module simon_host_if #(
    parameter int N  = 64,
    parameter int M  = 4,
    parameter int TO = 1023
) (
    input  logic                clk,
    input  logic                R,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_word,
    input  logic                in_is_key,
    input  logic                in_enc_dec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_word,
    output logic                key_ready,
    output logic                err,
    output logic                newKey,
    output logic                newData,
    output logic                enc_dec,
    output logic                readData,
    output logic [M-1:0][N-1:0] KEY,
    output logic [1:0][N-1:0]   BLOCK,
    input  logic                loadKey,
    input  logic                loadData,
    input  logic                doneKey,
    input  logic                doneData,
    input  logic [1:0][N-1:0]   outData
);

    localparam int c_IDX_W = (M > 1) ? $clog2(M) : 1;
    localparam int c_WD_W  = $clog2(TO + 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(M - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TO - 1);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_COL_KEY  = 4'd1;
    localparam logic [3:0] c_ST_COL_BLK  = 4'd2;
    localparam logic [3:0] c_ST_DISCARD  = 4'd3;
    localparam logic [3:0] c_ST_ISS_KEY  = 4'd4;
    localparam logic [3:0] c_ST_WAIT_KEY = 4'd5;
    localparam logic [3:0] c_ST_ISS_DAT  = 4'd6;
    localparam logic [3:0] c_ST_WAIT_DAT = 4'd7;
    localparam logic [3:0] c_ST_DRAIN0   = 4'd8;
    localparam logic [3:0] c_ST_DRAIN1   = 4'd9;

    logic [3:0]          r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WD_W-1:0]   r_wd;
    logic [M-1:0][N-1:0] r_kbuf;
    logic [M-1:0][N-1:0] r_key;
    logic [N-1:0]        r_blk_hi;
    logic [1:0][N-1:0]   r_block;
    logic                r_ed_lat;
    logic [N-1:0]        r_res_lo;
    logic [N-1:0]        r_out_word;
    logic                r_out_valid;
    logic                r_key_ready;
    logic                r_err;
    logic                r_new_key;
    logic                r_new_data;
    logic                r_enc_dec;
    logic                r_read_data;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_wait;
    logic                w_wd_hit;
    logic [M-1:0][N-1:0] w_key_next;

    assign w_in_ready = !R && (r_state == c_ST_IDLE    || r_state == c_ST_COL_KEY ||
                               r_state == c_ST_COL_BLK || r_state == c_ST_DISCARD);
    assign w_accept   = in_valid && w_in_ready;
    assign w_wait     = (r_state == c_ST_ISS_KEY) || (r_state == c_ST_WAIT_KEY) ||
                        (r_state == c_ST_ISS_DAT) || (r_state == c_ST_WAIT_DAT);
    assign w_wd_hit   = w_wait && (r_wd == c_WD_LAST);

    // Shift the key buffer up so the first word ends at index M-1.
    always_comb begin
        w_key_next    = r_kbuf;
        w_key_next[0] = in_word;
        for (int i = 1; i < M; i++) begin
            w_key_next[i] = r_kbuf[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_wd        <= '0;
            r_kbuf      <= '0;
            r_key       <= '0;
            r_blk_hi    <= '0;
            r_block     <= '0;
            r_ed_lat    <= 1'b0;
            r_res_lo    <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_key_ready <= 1'b0;
            r_err       <= 1'b0;
            r_new_key   <= 1'b0;
            r_new_data  <= 1'b0;
            r_enc_dec   <= 1'b0;
            r_read_data <= 1'b0;
        end else begin
            r_err       <= 1'b0;
            r_read_data <= 1'b0;
            if (w_wait) begin
                r_wd <= r_wd + 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (in_is_key) begin
                            r_kbuf <= w_key_next;
                            if (M == 1) begin
                                r_key       <= w_key_next;
                                r_new_key   <= 1'b1;
                                r_key_ready <= 1'b0;
                                r_wd        <= '0;
                                r_state     <= c_ST_ISS_KEY;
                            end else begin
                                r_idx   <= c_IDX_W'(1);
                                r_state <= c_ST_COL_KEY;
                            end
                        end else if (!r_key_ready) begin
                            r_state <= c_ST_DISCARD;
                        end else begin
                            r_blk_hi <= in_word;
                            r_ed_lat <= in_enc_dec;
                            r_state  <= c_ST_COL_BLK;
                        end
                    end
                end
                c_ST_COL_KEY: begin
                    if (w_accept) begin
                        r_kbuf <= w_key_next;
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == c_IDX_LAST) begin
                            r_key       <= w_key_next;
                            r_new_key   <= 1'b1;
                            r_key_ready <= 1'b0;
                            r_wd        <= '0;
                            r_state     <= c_ST_ISS_KEY;
                        end
                    end
                end
                c_ST_COL_BLK: begin
                    if (w_accept) begin
                        r_block    <= {r_blk_hi, in_word};
                        r_enc_dec  <= r_ed_lat;
                        r_new_data <= 1'b1;
                        r_wd       <= '0;
                        r_state    <= c_ST_ISS_DAT;
                    end
                end
                c_ST_DISCARD: begin
                    if (w_accept) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_ISS_KEY: begin
                    if (loadKey) begin
                        r_new_key <= 1'b0;
                        r_wd      <= '0;
                        r_state   <= c_ST_WAIT_KEY;
                    end else if (w_wd_hit) begin
                        r_new_key   <= 1'b0;
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_WAIT_KEY: begin
                    if (doneKey) begin
                        r_key_ready <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else if (w_wd_hit) begin
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_ISS_DAT: begin
                    if (loadData) begin
                        r_new_data <= 1'b0;
                        r_wd       <= '0;
                        r_state    <= c_ST_WAIT_DAT;
                    end else if (w_wd_hit) begin
                        r_new_data  <= 1'b0;
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_WAIT_DAT: begin
                    if (doneData) begin
                        r_out_word  <= outData[1];
                        r_res_lo    <= outData[0];
                        r_read_data <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DRAIN0;
                    end else if (w_wd_hit) begin
                        r_err       <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_DRAIN0: begin
                    if (out_ready) begin
                        r_out_word <= r_res_lo;
                        r_state    <= c_ST_DRAIN1;
                    end
                end
                c_ST_DRAIN1: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign key_ready = r_key_ready;
    assign err       = r_err;
    assign newKey    = r_new_key;
    assign newData   = r_new_data;
    assign enc_dec   = r_enc_dec;
    assign readData  = r_read_data;
    assign KEY       = r_key;
    assign BLOCK     = r_block;

endmodule
`default_nettype wire

// File: doc/simon_host_if.md
# simon_host_if

Host-side driver for the SIMON 128/256 cipher core: the initiating end of the core's key/data handshake. It takes 64-bit words from an upstream valid/ready stream and assembles them into key groups (M words) or block groups (2 words). It drives newKey/KEY and newData/BLOCK/enc_dec into the core, acknowledges results with readData, and returns each result as two words on a downstream valid/ready stream. It sits between the system bus adapter and the cipher core, with a watchdog covering every core wait.

## Interface
- N, 64, word width (core half-block width)
- M, 4, key words
- TO, 1023, watchdog limit in cycles per core wait; counter width $clog2(TO+1)
- clk  in  1  clock, all logic on rising edge
- R  in  1  synchronous active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid && in_ready
- in_word  in  N  upstream word
- in_is_key  in  1  group type, sampled on first word of group only
- in_enc_dec  in  1  1=encrypt, 0=decrypt, sampled on first word of block group only
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts
- out_word  out  N  result word
- key_ready  out  1  expanded key resident in core
- err  out  1  one-cycle error pulse
- newKey, newData, enc_dec, readData  out  1 each  core handshake drives
- KEY  out  [M-1:0][N-1:0]  core key bus
- BLOCK  out  [1:0][N-1:0]  core block bus
- loadKey, loadData, doneKey, doneData  in  1 each  core handshake returns
- outData  in  [1:0][N-1:0]  core result

## Operation
- Core contract:
  - Request: driver holds newX and its bus stable until the core pulses loadX.
  - Completion: doneX high marks completion.
  - Data result: doneData stays high until readData is pulsed, and the core clears it the cycle after.
- Word order:
  - Key: first key word → KEY[M-1], last → KEY[0].
  - Block: first block word → BLOCK[1], second → BLOCK[0].
  - Result: out_word emits outData[1] then outData[0].
- FSM states:
  - IDLE: in_ready=1. On an accepted word, store it and go to COL_KEY or COL_BLK per in_is_key.
    - If in_is_key=0 and key_ready=0, go to DISCARD instead.
    - If M=1 or the group is complete, go straight to the issue state.
  - COL_KEY / COL_BLK: in_ready=1 and word index increments per accept. On the last word, go to ISS_KEY / ISS_DAT.
  - DISCARD: in_ready=1. Consume the second block word, pulse err, go to IDLE.
  - ISS_KEY: newKey=1, key_ready cleared on entry. On loadKey, go to WAIT_KEY.
  - WAIT_KEY: on doneKey, set key_ready=1 and go to IDLE.
  - ISS_DAT: newData=1, enc_dec=latched in_enc_dec. On loadData, go to WAIT_DAT.
  - WAIT_DAT: on doneData, capture outData, assert readData for exactly one cycle, go to DRAIN0.
  - DRAIN0 / DRAIN1: out_valid=1. Advance on out_ready; DRAIN1 returns to IDLE.
  - in_ready=0 in ISS_*, WAIT_*, DRAIN*.
- Watchdog:
  - Counter clears on entry to ISS_KEY, WAIT_KEY, ISS_DAT and WAIT_DAT, and increments each cycle in those states.
  - On reaching TO:
    - pulse err
    - drop newKey/newData
    - clear key_ready
    - go to IDLE
- A key group always replaces the resident key; a mid-stream key reload is legal only from IDLE.
- KEY/BLOCK registers hold their last value outside the issue states.

## Timing
- During the R cycle every register clears: state IDLE, key_ready=0, err=0, newKey=newData=readData=0, enc_dec=0, KEY=0, BLOCK=0, out_valid=0, out_word=0.
- in_ready is gated low while R=1 and is 1 from the first cycle after R falls.
- Reset mid-operation:
  - Core handshakes are abandoned.
  - The partial group is dropped.
  - key_ready=0.
- Issue timing:
  - newKey rises the cycle after the M-th key word is accepted; newData rises the cycle after the 2nd block word is accepted.
  - newX falls the cycle after loadX is sampled high.
  - loadX and doneX high in the same cycle: take loadX, then doneX is sampled next cycle. Core must hold doneX level, so no event is lost.
- Result path:
  - readData is high the cycle after doneData is first sampled. outData is registered in that same sampling edge.
  - doneData is ignored in DRAIN*.
  - out_valid rises together with readData.
  - Minimum result-to-second-word latency: 2 cycles with out_ready=1. out_word and out_valid hold under backpressure.
- Driver overhead:
  - Block path: IDLE→…→IDLE = 2 accept + 1 + core cycles + 1 + 2 drain.
  - Key path: M accept + 1 + core + 1.
- err is a single-cycle pulse. Timeout and discard cannot coincide.

## Test plan
- Reset: hold R=1 with in_valid=1 → in_ready=0, all outputs 0. Release R → in_ready=1 next cycle.
- Known-answer encrypt:
  - Stimulus:
    - key words 1f1e1d1c1b1a1918, 1716151413121110, 0f0e0d0c0b0a0908, 0706050403020100
    - then block 74206e69206d6f6f, 6d69732061207369 with enc_dec=1
  - Response:
    - key_ready=1 before newData rises
    - out_word sequence 8d2b5579afc8a3a0, 3bf72a87efe7b868
    - readData high exactly one cycle
- Known-answer decrypt: same key resident, block 8d2b5579afc8a3a0, 3bf72a87efe7b868 with enc_dec=0 → outputs 74206e69206d6f6f, 6d69732061207369, with no key reload.
- Block before key: after reset, send a 2-word block group → both words accepted, err pulses once, newData never rises, state returns to IDLE.
- Backpressure: hold out_ready=0 for 20 cycles after doneData → out_word stable at first word, in_ready=0. The second word appears only after the first handshake.
- Watchdog with TO=16: stub core never pulses loadData → newData drops and err pulses 16 cycles after ISS_DAT entry, key_ready=0, and the next block group is discarded with err.
